// File: rtl/lc3b_types.sv
// lc3b_types: shared word type, performance-counter count and sat_flags bit order
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  localparam int PERF_NUM_COUNTERS = 10;
  typedef enum logic [3:0] {
    IF_STALL = 0, MEM_STALL, IC_HIT, IC_MISS, DC_HIT, DC_MISS, L2_HIT, L2_MISS, BR, BR_MISPRED
  } perf_idx_t;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: saturating lc3b_word counter (clk, reset_n, inc, clr -> count, sticky sat), clear beats increment
module perf_counter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     inc,
  input  logic     clr,
  output lc3b_word count,
  output logic     sat
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc) begin
      count <= &count ? count : count + 1'b1;
      sat   <= sat | (&count);
    end
endmodule

// File: rtl/perf_counters.sv
// perf_counters: ten gated event/stall counters with per-counter clears and sticky sat_flags in perf_idx_t order
module perf_counters
  import lc3b_types::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         count_en,
  input  logic                         br_event,
  input  logic                         br_mispredict_event,
  input  logic                         icache_hit_event,
  input  logic                         icache_miss_event,
  input  logic                         dcache_hit_event,
  input  logic                         dcache_miss_event,
  input  logic                         l2_hit_event,
  input  logic                         l2_miss_event,
  input  logic                         if_stall,
  input  logic                         mem_stall,
  input  logic                         br_count_reset,
  input  logic                         br_mispredict_count_reset,
  input  logic                         icache_hit_count_reset,
  input  logic                         icache_miss_count_reset,
  input  logic                         dcache_hit_count_reset,
  input  logic                         dcache_miss_count_reset,
  input  logic                         l2_hit_count_reset,
  input  logic                         l2_miss_count_reset,
  input  logic                         if_stall_count_reset,
  input  logic                         mem_stall_count_reset,
  output lc3b_word                     br_count,
  output lc3b_word                     br_mispredict_count,
  output lc3b_word                     icache_hit_count,
  output lc3b_word                     icache_miss_count,
  output lc3b_word                     dcache_hit_count,
  output lc3b_word                     dcache_miss_count,
  output lc3b_word                     l2_hit_count,
  output lc3b_word                     l2_miss_count,
  output lc3b_word                     if_stall_count,
  output lc3b_word                     mem_stall_count,
  output logic [PERF_NUM_COUNTERS-1:0] sat_flags
);
  logic [PERF_NUM_COUNTERS-1:0] ev, clr;
  lc3b_word cnt [PERF_NUM_COUNTERS];
  assign ev = {br_mispredict_event, br_event, l2_miss_event, l2_hit_event, dcache_miss_event,
               dcache_hit_event, icache_miss_event, icache_hit_event, mem_stall, if_stall};
  assign clr = {br_mispredict_count_reset, br_count_reset, l2_miss_count_reset, l2_hit_count_reset,
                dcache_miss_count_reset, dcache_hit_count_reset, icache_miss_count_reset,
                icache_hit_count_reset, mem_stall_count_reset, if_stall_count_reset};
  for (genvar i = 0; i < PERF_NUM_COUNTERS; i++) begin : g_cnt
    perf_counter u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (count_en & ev[i]),
      .clr     (clr[i]),
      .count   (cnt[i]),
      .sat     (sat_flags[i])
    );
  end
  assign if_stall_count      = cnt[IF_STALL];
  assign mem_stall_count     = cnt[MEM_STALL];
  assign icache_hit_count    = cnt[IC_HIT];
  assign icache_miss_count   = cnt[IC_MISS];
  assign dcache_hit_count    = cnt[DC_HIT];
  assign dcache_miss_count   = cnt[DC_MISS];
  assign l2_hit_count        = cnt[L2_HIT];
  assign l2_miss_count       = cnt[L2_MISS];
  assign br_count            = cnt[BR];
  assign br_mispredict_count = cnt[BR_MISPRED];
endmodule

// File: tb/tb_perf_counters.sv
// tb_perf_counters: directed scoreboard bench for perf_counters
module tb_perf_counters;
  import lc3b_types::*;
  localparam int N = PERF_NUM_COUNTERS;
  typedef struct packed {
    lc3b_word [N-1:0] c;
    logic [N-1:0]     s;
  } snap_t;
  logic clk, reset_n, en;
  logic [N-1:0] ev, clr, sat_flags;
  lc3b_word obs [N];
  snap_t q[$];
  int m_cnt [N];
  logic [N-1:0] m_sat;
  int checks, errors;
  perf_counters dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .count_en                  (en),
    .br_event                  (ev[BR]),
    .br_mispredict_event       (ev[BR_MISPRED]),
    .icache_hit_event          (ev[IC_HIT]),
    .icache_miss_event         (ev[IC_MISS]),
    .dcache_hit_event          (ev[DC_HIT]),
    .dcache_miss_event         (ev[DC_MISS]),
    .l2_hit_event              (ev[L2_HIT]),
    .l2_miss_event             (ev[L2_MISS]),
    .if_stall                  (ev[IF_STALL]),
    .mem_stall                 (ev[MEM_STALL]),
    .br_count_reset            (clr[BR]),
    .br_mispredict_count_reset (clr[BR_MISPRED]),
    .icache_hit_count_reset    (clr[IC_HIT]),
    .icache_miss_count_reset   (clr[IC_MISS]),
    .dcache_hit_count_reset    (clr[DC_HIT]),
    .dcache_miss_count_reset   (clr[DC_MISS]),
    .l2_hit_count_reset        (clr[L2_HIT]),
    .l2_miss_count_reset       (clr[L2_MISS]),
    .if_stall_count_reset      (clr[IF_STALL]),
    .mem_stall_count_reset     (clr[MEM_STALL]),
    .br_count                  (obs[BR]),
    .br_mispredict_count       (obs[BR_MISPRED]),
    .icache_hit_count          (obs[IC_HIT]),
    .icache_miss_count         (obs[IC_MISS]),
    .dcache_hit_count          (obs[DC_HIT]),
    .dcache_miss_count         (obs[DC_MISS]),
    .l2_hit_count              (obs[L2_HIT]),
    .l2_miss_count             (obs[L2_MISS]),
    .if_stall_count            (obs[IF_STALL]),
    .mem_stall_count           (obs[MEM_STALL]),
    .sat_flags                 (sat_flags)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed running, expected finished");
    $fatal(1, "watchdog");
  end
  task automatic push_model();
    snap_t e;
    for (int i = 0; i < N; i++) e.c[i] = lc3b_word'(m_cnt[i]);
    e.s = m_sat;
    q.push_back(e);
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_sat = '0;
  endtask
  task automatic check(input string tag);
    snap_t e;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed 0 entries, expected 1", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        assert (obs[i] === e.c[i]) else begin
          errors++;
          $error("FAIL %s cnt[%0d]: observed %h expected %h", tag, i, obs[i], e.c[i]);
        end
      end
      checks++;
      assert (sat_flags === e.s) else begin
        errors++;
        $error("FAIL %s sat_flags: observed %b expected %b", tag, sat_flags, e.s);
      end
    end
  endtask
  task automatic tick(input string tag, input bit chk);
    for (int i = 0; i < N; i++)
      if (!reset_n) begin
        m_cnt[i] = 0;
        m_sat[i] = 1'b0;
      end else if (clr[i]) begin
        m_cnt[i] = 0;
        m_sat[i] = 1'b0;
      end else if (en && ev[i]) begin
        if (m_cnt[i] == 65535) m_sat[i] = 1'b1;
        else m_cnt[i]++;
      end
    if (chk) push_model();
    @(posedge clk);
    #1;
    if (chk) check(tag);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    en = 1'b1;
    ev = '0;
    clr = '0;
    model_reset();
    #1;
    push_model();
    check("async_reset");
    ev[DC_HIT] = 1'b1;
    tick("reset_hold", 1);
    ev = '0;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ev[DC_HIT] = 1'b1;
      tick("dc_hit", 1);
    end
    ev = '0;
    tick("dc_hit_idle", 1);
    ev[MEM_STALL] = 1'b1;
    for (int k = 0; k < 7; k++) tick("mem_stall", 1);
    en = 1'b0;
    for (int k = 0; k < 3; k++) tick("mem_stall_frozen", 1);
    en = 1'b1;
    ev = '0;
    tick("mem_stall_idle", 1);
    ev[BR_MISPRED] = 1'b1;
    tick("mispred_alone", 1);
    ev = '0;
    ev[IC_HIT] = 1'b1;
    ev[IC_MISS] = 1'b1;
    ev[L2_HIT] = 1'b1;
    ev[L2_MISS] = 1'b1;
    ev[DC_MISS] = 1'b1;
    tick("hit_miss_same", 1);
    ev = '0;
    for (int k = 0; k < 3; k++) begin
      ev[BR] = 1'b1;
      tick("br_pulse", 1);
    end
    clr[BR] = 1'b1;
    tick("br_clr_wins", 1);
    clr = '0;
    tick("br_next", 1);
    ev = '0;
    ev[IF_STALL] = 1'b1;
    tick("if_stall_pre", 1);
    clr[IF_STALL] = 1'b1;
    for (int k = 0; k < 4; k++) tick("if_clr_held", 1);
    clr = '0;
    tick("if_clr_release", 1);
    ev = '0;
    en = 1'b0;
    clr[DC_HIT] = 1'b1;
    tick("clr_while_disabled", 1);
    clr = '0;
    en = 1'b1;
    ev[IC_MISS] = 1'b1;
    clr[IC_MISS] = 1'b1;
    tick("ic_miss_clear", 1);
    clr = '0;
    for (int k = 0; k < 65534; k++) tick("preload", 0);
    tick("ic_miss_ffff", 1);
    tick("ic_miss_sat", 1);
    tick("ic_miss_sat_hold", 1);
    ev = '0;
    en = 1'b0;
    tick("sat_sticky", 1);
    en = 1'b1;
    clr[IC_MISS] = 1'b1;
    tick("sat_clear", 1);
    clr = '0;
    for (int k = 0; k < 9; k++) begin
      ev[L2_HIT] = 1'b1;
      tick("l2_hit", 1);
    end
    ev = '0;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    push_model();
    check("l2_async_reset");
    tick("reset_held", 1);
    reset_n = 1'b1;
    ev[L2_HIT] = 1'b1;
    tick("post_reset_count", 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
